// File: rtl/exe_muldiv_ctrl.sv
// Sequencer for the RV32M multiply/divide unit: radix-2 shift-add multiply and restoring divide.
// Optional feature: define MULDIV_EARLY_OUT_EN to finish zero-operand ops without iterating.
//
// state | meaning
// ------+---------------------------------------------------------------
// IDLE  | waiting for start_i; accepts an op when kill_i is low
// CALC  | one shift/add or shift/subtract iteration per cycle, 32 cycles
// DONE  | registered result presented with a one-cycle done_o strobe

module exe_muldiv_ctrl #(
    parameter int XLEN   = 32,
    parameter int ITER_W = 6
) (
    input  logic            clk_i,
    input  logic            rst_i,
    input  logic            start_i,
    input  logic [2:0]      funct3_i,
    input  logic [XLEN-1:0] dat_a_i,
    input  logic [XLEN-1:0] dat_b_i,
    input  logic            kill_i,
    output logic            stall_o,
    output logic            done_o,
    output logic [XLEN-1:0] result_o
);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_CALC = 2'd1,
        S_DONE = 2'd2
    } state_t;

    localparam logic [XLEN-1:0]   MIN_NEG  = {1'b1, {(XLEN-1){1'b0}}};
    localparam logic [ITER_W-1:0] CNT_LAST = ITER_W'(XLEN-1);
    localparam logic [ITER_W-1:0] CNT_ONE  = ITER_W'(1);

    state_t              state_q, state_d;
    logic [ITER_W-1:0]   cnt_q, cnt_d;
    logic [2:0]          funct3_q, funct3_d;
    logic [XLEN-1:0]     op_q, op_d;
    logic [2*XLEN-1:0]   acc_q, acc_d;
    logic                neg_a_q, neg_a_d;
    logic                neg_b_q, neg_b_d;
    logic [XLEN-1:0]     result_q, result_d;
    logic                done_q, done_d;

    logic                is_div_in;
    logic                sgn_a_in;
    logic                sgn_b_in;
    logic                neg_a_in;
    logic                neg_b_in;
    logic [XLEN-1:0]     mag_a;
    logic [XLEN-1:0]     mag_b;
    logic                div_by_zero;
    logic                div_ovf;
    logic                early_zero;
    logic [XLEN-1:0]     spec_res;
    logic                accept;

    logic [XLEN:0]       mul_sum;
    logic [2*XLEN-1:0]   mul_nx;
    logic [XLEN:0]       rem_sh;
    logic                rem_ge;
    logic [XLEN-1:0]     rem_sub;
    logic [2*XLEN-1:0]   div_nx;
    logic [2*XLEN-1:0]   acc_nx;

    logic [2*XLEN-1:0]   prod_fix;
    logic [XLEN-1:0]     quo_fix;
    logic [XLEN-1:0]     rem_fix;
    logic [XLEN-1:0]     res_fix;

    // Operand decode at accept: signedness, magnitudes and the ops that skip CALC
    always_comb begin
        is_div_in   = funct3_i[2];
        sgn_a_in    = (funct3_i == 3'd1) || (funct3_i == 3'd2) ||
                      (funct3_i == 3'd4) || (funct3_i == 3'd6);
        sgn_b_in    = (funct3_i == 3'd1) || (funct3_i == 3'd4) || (funct3_i == 3'd6);
        neg_a_in    = sgn_a_in && dat_a_i[XLEN-1];
        neg_b_in    = sgn_b_in && dat_b_i[XLEN-1];
        mag_a       = neg_a_in ? -dat_a_i : dat_a_i;
        mag_b       = neg_b_in ? -dat_b_i : dat_b_i;
        div_by_zero = is_div_in && (dat_b_i == '0);
        div_ovf     = ((funct3_i == 3'd4) || (funct3_i == 3'd6)) &&
                      (dat_a_i == MIN_NEG) && (dat_b_i == '1);
`ifdef MULDIV_EARLY_OUT_EN
        early_zero  = is_div_in ? ((dat_a_i == '0) && (dat_b_i != '0))
                                : ((dat_a_i == '0) || (dat_b_i == '0));
`else
        early_zero  = 1'b0;
`endif
        spec_res = '0;
        if (div_by_zero) begin
            spec_res = funct3_i[1] ? dat_a_i : '1;
        end else if (div_ovf) begin
            spec_res = funct3_i[1] ? '0 : MIN_NEG;
        end
        accept = (state_q == S_IDLE) && start_i && !kill_i;
    end

    // One iteration: multiply keeps {hi, multiplier}, divide keeps {remainder, dividend/quotient}
    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, op_q};
        mul_nx  = acc_q[0] ? {mul_sum, acc_q[XLEN-1:1]} : {1'b0, acc_q[2*XLEN-1:1]};

        rem_sh  = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        rem_ge  = rem_sh >= {1'b0, op_q};
        rem_sub = rem_sh[XLEN-1:0] - op_q;
        div_nx  = rem_ge ? {rem_sub, acc_q[XLEN-2:0], 1'b1}
                         : {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        acc_nx  = funct3_q[2] ? div_nx : mul_nx;
    end

    // Sign correction on the final iteration so result_q is ready in DONE
    always_comb begin
        prod_fix = (neg_a_q ^ neg_b_q) ? -acc_nx : acc_nx;
        quo_fix  = (neg_a_q ^ neg_b_q) ? -acc_nx[XLEN-1:0] : acc_nx[XLEN-1:0];
        rem_fix  = neg_a_q ? -acc_nx[2*XLEN-1:XLEN] : acc_nx[2*XLEN-1:XLEN];
        case (funct3_q)
            3'd0:    res_fix = prod_fix[XLEN-1:0];
            3'd1,
            3'd2,
            3'd3:    res_fix = prod_fix[2*XLEN-1:XLEN];
            3'd4,
            3'd5:    res_fix = quo_fix;
            default: res_fix = rem_fix;
        endcase
    end

    always_comb begin
        state_d  = state_q;
        cnt_d    = cnt_q;
        funct3_d = funct3_q;
        op_d     = op_q;
        acc_d    = acc_q;
        neg_a_d  = neg_a_q;
        neg_b_d  = neg_b_q;
        result_d = result_q;
        done_d   = 1'b0;

        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    funct3_d = funct3_i;
                    neg_a_d  = neg_a_in;
                    neg_b_d  = neg_b_in;
                    cnt_d    = '0;
                    if (div_by_zero || div_ovf || early_zero) begin
                        result_d = spec_res;
                        done_d   = 1'b1;
                        state_d  = S_DONE;
                    end else begin
                        acc_d   = {{XLEN{1'b0}}, is_div_in ? mag_a : mag_b};
                        op_d    = is_div_in ? mag_b : mag_a;
                        state_d = S_CALC;
                    end
                end
            end
            S_CALC: begin
                acc_d = acc_nx;
                cnt_d = cnt_q + CNT_ONE;
                if (cnt_q == CNT_LAST) begin
                    result_d = res_fix;
                    done_d   = 1'b1;
                    state_d  = S_DONE;
                end
            end
            default: begin
                state_d = S_IDLE;
            end
        endcase

        if (kill_i) begin
            state_d  = S_IDLE;
            done_d   = 1'b0;
            result_d = result_q;
        end
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q  <= S_IDLE;
            cnt_q    <= '0;
            funct3_q <= '0;
            op_q     <= '0;
            acc_q    <= '0;
            neg_a_q  <= 1'b0;
            neg_b_q  <= 1'b0;
            result_q <= '0;
            done_q   <= 1'b0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            funct3_q <= funct3_d;
            op_q     <= op_d;
            acc_q    <= acc_d;
            neg_a_q  <= neg_a_d;
            neg_b_q  <= neg_b_d;
            result_q <= result_d;
            done_q   <= done_d;
        end
    end

    // stall_o drops in DONE so the pipeline consumes result_o that cycle
    assign stall_o  = accept || (state_q == S_CALC);
    assign done_o   = done_q && !kill_i;
    assign result_o = result_q;

endmodule
